// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop input synchroniser, phase-aligned tick
// generator, 3-sample majority vote at mid-bit, configurable data width,
// parity mode and stop-bit count, separate parity and framing error flags.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 1,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned TICK_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
  localparam int unsigned DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TCNT_W       = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W       = $clog2(DATA_BITS + 1);
  localparam int unsigned SAMP_LO      = OVERSAMPLE / 2 - 1;
  localparam int unsigned SAMP_MID     = OVERSAMPLE / 2;
  localparam int unsigned SAMP_RES     = OVERSAMPLE / 2 + 1;
  localparam int unsigned BIT_LAST     = OVERSAMPLE - 1;
  localparam logic        ODD_PAR      = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                 sync1_q, sync2_q, line_d_q;
  logic                 line, fall;
  logic [DIV_W-1:0]     div_cnt_q;
  logic [TCNT_W-1:0]    tick_cnt_q;
  logic [BCNT_W-1:0]    bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 samp0_q, samp1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;

  logic tick, at_lo, at_mid, at_res, at_end;
  logic bit_val, last_data, last_stop;
  logic start_c, shift_c, par_chk_c, stop_chk_c, commit_c, data_end_c, stop_end_c;

  // Synchronise the raw line; the third flop provides falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      line_d_q <= 1'b1;
    end else begin
      sync1_q  <= uart_i;
      sync2_q  <= sync1_q;
      line_d_q <= sync2_q;
    end
  end

  assign line = sync2_q;
  assign fall = line_d_q & ~sync2_q;

  // Tick and sample-point decode; ticks only run while a frame is in progress.
  assign tick      = (state_q != ST_IDLE) && (div_cnt_q == DIV_W'(TICK_DIV - 1));
  assign at_lo     = tick && (tick_cnt_q == TCNT_W'(SAMP_LO));
  assign at_mid    = tick && (tick_cnt_q == TCNT_W'(SAMP_MID));
  assign at_res    = tick && (tick_cnt_q == TCNT_W'(SAMP_RES));
  assign at_end    = tick && (tick_cnt_q == TCNT_W'(BIT_LAST));
  assign bit_val   = (samp0_q & samp1_q) | (samp0_q & line) | (samp1_q & line);
  assign last_data = (bit_cnt_q == BCNT_W'(DATA_BITS - 1));
  assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (at_res && bit_val) state_d = ST_IDLE;
        else if (at_end)       state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_end && last_data) begin
          if (PARITY != 0) state_d = ST_PARITY;
          else             state_d = ST_STOP;
        end
      end
      ST_PARITY: begin
        if (at_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (at_res && last_stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM control strobes for the datapath.
  always_comb begin
    start_c    = 1'b0;
    shift_c    = 1'b0;
    par_chk_c  = 1'b0;
    stop_chk_c = 1'b0;
    commit_c   = 1'b0;
    data_end_c = 1'b0;
    stop_end_c = 1'b0;
    case (state_q)
      ST_IDLE:   start_c = fall;
      ST_DATA: begin
        shift_c    = at_res;
        data_end_c = at_end;
      end
      ST_PARITY: par_chk_c = at_res;
      ST_STOP: begin
        stop_chk_c = at_res;
        commit_c   = at_res && last_stop;
        stop_end_c = at_end;
      end
      default: ;
    endcase
  end

  // Clock divider, restarted on the start edge so ticks align to the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else if (start_c || (state_q == ST_IDLE)) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == DIV_W'(TICK_DIV - 1)) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // Tick position within the current bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (start_c) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      if (tick_cnt_q == TCNT_W'(BIT_LAST)) tick_cnt_q <= '0;
      else                                 tick_cnt_q <= tick_cnt_q + TCNT_W'(1);
    end
  end

  // Data-bit and stop-bit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else if (start_c) begin
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      if (data_end_c) bit_cnt_q  <= bit_cnt_q + BCNT_W'(1);
      if (stop_end_c) stop_cnt_q <= stop_cnt_q + 1'b1;
    end
  end

  // Capture the first two mid-bit samples; the third is the live line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp0_q <= 1'b0;
      samp1_q <= 1'b0;
    end else begin
      if (at_lo)  samp0_q <= line;
      if (at_mid) samp1_q <= line;
    end
  end

  // LSB-first shift register and sticky per-frame error bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else if (start_c) begin
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (shift_c)               shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
      if (par_chk_c)             perr_q  <= (bit_val != ((^shift_q) ^ ODD_PAR));
      if (stop_chk_c && !bit_val) ferr_q <= 1'b1;
    end
  end

  // Registered outputs; the word and its flags update together on the final stop resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= commit_c;
      rx_busy  <= (state_d != ST_IDLE);
      if (commit_c) begin
        rx_data    <= shift_q;
        parity_err <= (PARITY != 0) && perr_q;
        frame_err  <= ferr_q | ~bit_val;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: three instances (even/8/1, odd/8/1, none/7/2)
// share clock and reset; frames are compared against a bit-level model.
module tb_uart_rx_os;

  localparam int unsigned BIT_CLK = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] lines;

  logic [7:0] rx_data_e, rx_data_o;
  logic [6:0] rx_data_n;
  logic       valid_e, valid_o, valid_n;
  logic       perr_e, perr_o, perr_n;
  logic       ferr_e, ferr_o, ferr_n;
  logic       busy_e, busy_o, busy_n;

  int total;
  int bad;

  logic [12:0] rq[$];
  int          run[3];
  int          lastw[3];
  int          maxw[3];
  logic [2:0]  v, pe, fe;
  logic [8:0]  dd[3];

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .uart_i(lines[0]), .rx_data(rx_data_e),
    .rx_valid(valid_e), .parity_err(perr_e), .frame_err(ferr_e), .rx_busy(busy_e));

  uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .uart_i(lines[1]), .rx_data(rx_data_o),
    .rx_valid(valid_o), .parity_err(perr_o), .frame_err(ferr_o), .rx_busy(busy_o));

  uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
               .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_np (
    .clk(clk), .rst_n(rst_n), .uart_i(lines[2]), .rx_data(rx_data_n),
    .rx_valid(valid_n), .parity_err(perr_n), .frame_err(ferr_n), .rx_busy(busy_n));

  assign v     = {valid_n, valid_o, valid_e};
  assign pe    = {perr_n, perr_o, perr_e};
  assign fe    = {ferr_n, ferr_o, ferr_e};
  assign dd[0] = {1'b0, rx_data_e};
  assign dd[1] = {1'b0, rx_data_o};
  assign dd[2] = {2'b00, rx_data_n};

  // Record each rx_valid pulse once (at its first cycle) and its width.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (v[k]) begin
        if (run[k] == 0) rq.push_back({2'(k), fe[k], pe[k], dd[k]});
        run[k]++;
      end else if (run[k] != 0) begin
        lastw[k] = run[k];
        if (run[k] > maxw[k]) maxw[k] = run[k];
        run[k] = 0;
      end
    end
  end

  function automatic logic [12:0] ent(input int k, input logic [8:0] d,
                                      input logic p, input logic f);
    return {2'(k), f, p, d};
  endfunction

  // Expected result from the frame's line bits: parity counted over data+parity bit.
  function automatic logic [12:0] model(input int k, input logic [8:0] data,
                                        input logic par_bit, input logic [1:0] stop_v);
    int nd, mode, nstop, ones;
    logic [8:0] d;
    logic p, f;
    nd    = (k == 2) ? 7 : 8;
    mode  = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
    nstop = (k == 2) ? 2 : 1;
    d     = data & 9'((1 << nd) - 1);
    ones  = $countones(d) + int'(par_bit);
    p     = (mode == 1) ? ((ones % 2) != 0) : (mode == 2) ? ((ones % 2) != 1) : 1'b0;
    f     = !stop_v[0] || ((nstop == 2) && !stop_v[1]);
    return ent(k, d, p, f);
  endfunction

  function automatic logic [12:0] pop_result();
    if (rq.size() == 0) return 13'h1FFF;
    return rq.pop_front();
  endfunction

  task automatic drive(input int k, input logic b, input int n);
    lines[k] = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stop_v);
    int nd;
    nd = (k == 2) ? 7 : 8;
    drive(k, 1'b0, BIT_CLK);
    for (int i = 0; i < nd; i++) drive(k, data[i], BIT_CLK);
    if (k != 2) drive(k, par_bit, BIT_CLK);
    drive(k, stop_v[0], BIT_CLK);
    if (k == 2) drive(k, stop_v[1], BIT_CLK);
    lines[k] = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] st_e, st_o;
    logic [10:0] st_n;
    rst_n = 1'b0;
    lines = 3'b111;
    repeat (3) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      st_e = {rx_data_e, valid_e, perr_e, ferr_e, busy_e};
      st_o = {rx_data_o, valid_o, perr_o, ferr_o, busy_o};
      st_n = {rx_data_n, valid_n, perr_n, ferr_n, busy_n};
      total++; if (st_e !== 12'h000) begin bad++; $display("FAIL reset_even pass=%0d got=%h exp=000", pass, st_e); end
      total++; if (st_o !== 12'h000) begin bad++; $display("FAIL reset_odd pass=%0d got=%h exp=000", pass, st_o); end
      total++; if (st_n !== 11'h000) begin bad++; $display("FAIL reset_np pass=%0d got=%h exp=000", pass, st_n); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_even_parity();
    logic [12:0] got;
    rq.delete();
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    got = pop_result();
    total++; if (got !== ent(0, 9'h0A5, 1'b0, 1'b0)) begin bad++; $display("FAIL even_a5 got=%h exp=%h", got, ent(0, 9'h0A5, 1'b0, 1'b0)); end
    repeat (8) @(negedge clk);
    total++; if (rq.size() !== 0) begin bad++; $display("FAIL even_single_pulse extra=%0d exp=0", rq.size()); end
    total++; if (lastw[0] !== 1) begin bad++; $display("FAIL even_pulse_width got=%0d exp=1", lastw[0]); end
  endtask

  task automatic test_odd_parity();
    logic [12:0] got;
    rq.delete();
    send_frame(1, 9'h03C, 1'b0, 2'b11);
    got = pop_result();
    total++; if (got !== ent(1, 9'h03C, 1'b1, 1'b0)) begin bad++; $display("FAIL odd_bad_par got=%h exp=%h", got, ent(1, 9'h03C, 1'b1, 1'b0)); end
    drive(1, 1'b1, 8);
    send_frame(1, 9'h03C, 1'b1, 2'b11);
    got = pop_result();
    total++; if (got !== ent(1, 9'h03C, 1'b0, 1'b0)) begin bad++; $display("FAIL odd_good_par got=%h exp=%h", got, ent(1, 9'h03C, 1'b0, 1'b0)); end
    drive(1, 1'b1, 8);
  endtask

  task automatic test_two_stop();
    logic [12:0] got;
    rq.delete();
    send_frame(2, 9'h055, 1'b0, 2'b01);
    got = pop_result();
    total++; if (got !== ent(2, 9'h055, 1'b0, 1'b1)) begin bad++; $display("FAIL stop2_low got=%h exp=%h", got, ent(2, 9'h055, 1'b0, 1'b1)); end
    drive(2, 1'b1, BIT_CLK);
  endtask

  task automatic test_back_to_back();
    logic [12:0] got;
    rq.delete();
    send_frame(2, 9'h001, 1'b0, 2'b11);
    send_frame(2, 9'h07F, 1'b0, 2'b11);
    drive(2, 1'b1, 8);
    got = pop_result();
    total++; if (got !== ent(2, 9'h001, 1'b0, 1'b0)) begin bad++; $display("FAIL b2b_first got=%h exp=%h", got, ent(2, 9'h001, 1'b0, 1'b0)); end
    got = pop_result();
    total++; if (got !== ent(2, 9'h07F, 1'b0, 1'b0)) begin bad++; $display("FAIL b2b_second got=%h exp=%h", got, ent(2, 9'h07F, 1'b0, 1'b0)); end
  endtask

  task automatic test_glitch();
    logic saw_busy;
    int   waited;
    rq.delete();
    saw_busy = 1'b0;
    lines[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy_e) saw_busy = 1'b1;
    end
    lines[0] = 1'b1;
    waited = 0;
    while (waited < 16 && (busy_e || !saw_busy)) begin
      @(negedge clk);
      if (busy_e) saw_busy = 1'b1;
      waited++;
    end
    total++; if (saw_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
    total++; if (busy_e !== 1'b0) begin bad++; $display("FAIL glitch_busy_clear got=%b exp=0 after=%0d", busy_e, waited); end
    repeat (24) @(negedge clk);
    total++; if (rq.size() !== 0) begin bad++; $display("FAIL glitch_no_valid got=%0d exp=0", rq.size()); end
  endtask

  task automatic test_spike();
    logic [12:0] got;
    rq.delete();
    drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b0, 9);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, BIT_CLK - 10);
    for (int i = 1; i < 8; i++) drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b1, BIT_CLK);
    got = pop_result();
    total++; if (got !== ent(0, 9'h000, 1'b0, 1'b0)) begin bad++; $display("FAIL spike_reject got=%h exp=%h", got, ent(0, 9'h000, 1'b0, 1'b0)); end
    drive(0, 1'b1, 8);
  endtask

  task automatic test_reset_mid();
    logic [12:0] got;
    logic [11:0] st_e;
    rq.delete();
    send_frame(0, 9'h05A, 1'b1, 2'b11);
    got = pop_result();
    total++; if (got !== ent(0, 9'h05A, 1'b1, 1'b0)) begin bad++; $display("FAIL pre_reset_frame got=%h exp=%h", got, ent(0, 9'h05A, 1'b1, 1'b0)); end
    drive(0, 1'b1, 8);
    drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b1, 3 * BIT_CLK + 8);
    total++; if (busy_e !== 1'b1) begin bad++; $display("FAIL mid_frame_busy got=%b exp=1", busy_e); end
    rst_n = 1'b0;
    #1;
    st_e = {rx_data_e, valid_e, perr_e, ferr_e, busy_e};
    total++; if (st_e !== 12'h000) begin bad++; $display("FAIL reset_mid_outputs got=%h exp=000", st_e); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 8 * BIT_CLK);
    total++; if (rq.size() !== 0) begin bad++; $display("FAIL reset_mid_no_valid got=%0d exp=0", rq.size()); end
    send_frame(0, 9'h0C3, 1'b0, 2'b11);
    got = pop_result();
    total++; if (got !== ent(0, 9'h0C3, 1'b0, 1'b0)) begin bad++; $display("FAIL after_reset_c3 got=%h exp=%h", got, ent(0, 9'h0C3, 1'b0, 1'b0)); end
    drive(0, 1'b1, 8);
  endtask

  task automatic test_random();
    logic [12:0] got, exp;
    logic [8:0]  data;
    logic        par_bit;
    logic [1:0]  stop_v;
    int          gap;
    for (int k = 0; k < 3; k++) begin
      rq.delete();
      maxw[k] = 0;
      for (int n = 0; n < 20; n++) begin
        data    = 9'($urandom);
        par_bit = (k == 2) ? 1'b0 : 1'($urandom);
        stop_v  = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
        exp     = model(k, data, par_bit, stop_v);
        send_frame(k, data, par_bit, stop_v);
        got = pop_result();
        total++; if (got !== exp) begin bad++; $display("FAIL rand_frame dut=%0d n=%0d got=%h exp=%h", k, n, got, exp); end
        gap = $urandom_range(0, 20);
        if (!stop_v[(k == 2) ? 1 : 0] && gap < 2) gap = 2;
        drive(k, 1'b1, gap);
      end
      drive(k, 1'b1, 8);
      total++; if (maxw[k] !== 1) begin bad++; $display("FAIL rand_pulse_width dut=%0d got=%0d exp=1", k, maxw[k]); end
      total++; if (rq.size() !== 0) begin bad++; $display("FAIL rand_extra_valid dut=%0d got=%0d exp=0", k, rq.size()); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    lines = 3'b111;
    rst_n = 1'b0;
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_two_stop();
    test_back_to_back();
    test_glitch();
    test_spike();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised oversampling UART receiver. Generalises the fixed 8-bit, even-parity, single-phase-sampled receiver to configurable data width, parity mode and stop-bit count.
- Adds asynchronous reset, input synchronisation, majority-vote mid-bit sampling, false-start rejection and separate parity/framing error reporting.
- Sits between the pad-side serial input and the byte/command consumers (FIFO, command decoder). All outputs are in the `clk` domain.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; even, >=8.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 1, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_i  input  1  raw serial line; idle high; asynchronous to clk.
- rx_data  output  DATA_BITS  last received word, LSB = first data bit.
- rx_valid  output  1  one-clk pulse at the end of every accepted frame.
- parity_err  output  1  parity mismatch for the word in rx_data; always 0 when PARITY=0.
- frame_err  output  1  at least one stop bit sampled low for the word in rx_data.
- rx_busy  output  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset (async assert, sync deassert in the reset-sync stage): rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0; FSM=IDLE; synchroniser flops=1; all counters=0.
- Synchroniser: uart_i passes through a 2-flop synchroniser, then a third flop for falling-edge detection. The synchronised line is the "line" below.
- Tick generator: TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, minimum 1.
  - Produces a one-clk tick every TICK_DIV clk cycles.
  - Cleared to 0 on start-edge detection so that ticks are phase-aligned to the frame.
- Bit timing:
  - tick_cnt counts 0..OVERSAMPLE-1 per bit.
  - The line is sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Bit value = majority of the 3 samples, resolved on tick OVERSAMPLE/2+1.
  - Next bit begins when tick_cnt wraps from OVERSAMPLE-1 to 0.
- FSM states and transitions:
  - IDLE: rx_busy=0. A line falling edge moves to START and resets the tick divider and tick_cnt.
  - START: on majority resolve:
    - Bit = 1 (false start, glitch): go to IDLE. No outputs change.
    - Bit = 0: continue in START to the bit boundary, then go to DATA with bit_cnt=0.
  - DATA: shift each resolved bit in LSB-first; bit_cnt increments on each boundary. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: expected = XOR of data bits (even mode) or its inverse (odd mode). Mismatch sets an internal perr. The frame is NOT aborted on mismatch. Go to STOP at the boundary.
  - STOP: each stop bit is resolved; a 0 sets an internal ferr.
    - On resolve of the final stop bit, not at its boundary: rx_data, parity_err and frame_err update, rx_valid pulses high for exactly one clk, and the FSM goes to IDLE.
    - Returning mid-stop-bit allows back-to-back frames with no idle gap.
- Error flags hold with rx_data until the next rx_valid. A break (line held low) yields rx_data=0 and frame_err=1, then no new frame until the line returns high and falls again.
- Latency: rx_valid asserts 3 clk (synchroniser + edge) plus the time to the last stop-bit resolve point after the line start edge.
- An edge during any non-IDLE state is ignored; sampling only.
- Reset mid-frame: immediate return to the reset state; the partial frame is discarded and no rx_valid is produced.

Test Plan:
- Bench params: CLK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16, so TICK_DIV=1 and one bit = 16 clk.
- Even parity, 1 stop, send 0xA5 with parity bit 0 -> one rx_valid pulse; rx_data=0xA5, parity_err=0, frame_err=0; rx_valid exactly 1 clk wide.
- Odd parity, send 0x3C with parity bit 0 (wrong; correct bit is 1) -> rx_valid; rx_data=0x3C, parity_err=1, frame_err=0. Then send 0x3C with parity bit 1 -> parity_err=0.
- PARITY=0, STOP_BITS=2, DATA_BITS=7: send 0x55 with the second stop bit low -> rx_data=0x55, frame_err=1. Then back-to-back frames 0x01 and 0x7F with no idle gap -> two rx_valid pulses, values in order.
- 4-clk low glitch on uart_i while idle -> no rx_valid; rx_busy returns to 0 within 16 clk.
- 1-clk high spike on sample tick 8 of data bit 0 of 0x00 -> rx_data=0x00 (majority rejects the spike).
- rst_n low for 2 clk during data bit 3 of a frame -> all outputs 0 immediately; no rx_valid for that frame. The next full frame 0xC3 is received correctly.
